// File: rtl/adc_sample_scheduler.sv
// adc_sample_scheduler: tick-paced round-robin ADC requests,
// per-channel boxcar averaging, overrun/timeout flags.
module adc_sample_scheduler #(
  parameter int NUM_CH     = 2,
  parameter int SAMPLE_DIV = 50000,
  parameter int AVG_LOG2   = 3,
  parameter int TIMEOUT    = 255
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic [1:0]  ch_en,
  output logic        adc_start,
  output logic        adc_ch,
  input  logic        adc_done,
  input  logic [11:0] adc_data,
  output logic [11:0] ch0_avg,
  output logic [11:0] ch1_avg,
  output logic        avg_valid,
  output logic        avg_ch,
  output logic        overrun,
  output logic        timeout_err
);

  localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int AW = 12 + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'((1 << AVG_LOG2) - 1);
  localparam logic [7:0]    TO_LIM    = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_ACCUM,
    S_PUB
  } state_t;

  state_t state, nxt;

  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic          last_ch;
  logic          cur_ch;
  logic [7:0]    timer;
  logic [11:0]   sample;
  logic          disc;
  logic          drop;
  logic          busy;
  logic          pick_ok;
  logic          pick_ch;
  logic [AW-1:0] acc [2];
  logic [CW-1:0] cnt [2];
  logic [11:0]   avg [2];
  logic [AW-1:0] sum;

  assign tick    = (tick_cnt == TICK_LAST);
  assign busy    = (state != S_IDLE);
  assign drop    = disc | ~ch_en[cur_ch];
  assign sum     = acc[cur_ch] + AW'(sample);
  assign adc_ch  = cur_ch;
  assign ch0_avg = avg[0];
  assign ch1_avg = avg[1];

  // Round-robin pick: first enabled channel after the last one served.
  always_comb begin
    pick_ok = 1'b0;
    pick_ch = 1'b0;
    if (NUM_CH == 1) begin
      pick_ok = ch_en[0];
    end else if (ch_en[~last_ch]) begin
      pick_ok = 1'b1;
      pick_ch = ~last_ch;
    end else if (ch_en[last_ch]) begin
      pick_ok = 1'b1;
      pick_ch = last_ch;
    end
  end

  // FSM state register.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) state <= S_IDLE;
    else          state <= nxt;
  end

  // FSM next-state and handshake outputs.
  always_comb begin
    nxt       = state;
    adc_start = 1'b0;
    avg_valid = 1'b0;
    avg_ch    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (tick && pick_ok) nxt = S_REQ;
      end
      S_REQ: begin
        adc_start = 1'b1;
        nxt       = S_WAIT;
      end
      S_WAIT: begin
        if (adc_done)
          nxt = drop ? S_IDLE : S_ACCUM;
        else if (timer == TO_LIM)
          nxt = S_IDLE;
      end
      S_ACCUM: begin
        if (!drop && cnt[cur_ch] == CNT_LAST)
          nxt = S_PUB;
        else
          nxt = S_IDLE;
      end
      S_PUB: begin
        avg_valid = 1'b1;
        avg_ch    = cur_ch;
        nxt       = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  // Tick counter, timer, accumulators, averages and sticky flags.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      tick_cnt    <= '0;
      last_ch     <= 1'b1;
      cur_ch      <= 1'b0;
      timer       <= '0;
      sample      <= '0;
      disc        <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        acc[i] <= '0;
        cnt[i] <= '0;
        avg[i] <= '0;
      end
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      if (tick && busy) overrun <= 1'b1;

      if (!busy)               disc <= 1'b0;
      else if (!ch_en[cur_ch]) disc <= 1'b1;

      unique case (state)
        S_IDLE: begin
          if (tick && pick_ok) cur_ch <= pick_ch;
        end
        S_REQ: begin
          last_ch <= cur_ch;
          timer   <= '0;
        end
        S_WAIT: begin
          if (adc_done)
            sample <= adc_data;
          else if (timer == TO_LIM)
            timeout_err <= 1'b1;
          else
            timer <= timer + 1'b1;
        end
        S_ACCUM: begin
          if (!drop) begin
            acc[cur_ch] <= sum;
            cnt[cur_ch] <= cnt[cur_ch] + 1'b1;
            if (cnt[cur_ch] == CNT_LAST)
              avg[cur_ch] <= 12'(sum >> AVG_LOG2);
          end
        end
        S_PUB: begin
          acc[cur_ch] <= '0;
          cnt[cur_ch] <= '0;
        end
        default: ;
      endcase

      for (int i = 0; i < 2; i++) begin
        if (!ch_en[i] && !(busy && cur_ch == 1'(i))) begin
          acc[i] <= '0;
          cnt[i] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// tb_adc_sample_scheduler: directed vector table plus
// timeout, overrun, disable and mid-conversion reset sequences.
module tb_adc_sample_scheduler;

  logic        CLOCK_50;
  logic        RESET_N;
  logic [1:0]  ch_en;
  logic        adc_start;
  logic        adc_ch;
  logic        adc_done;
  logic [11:0] adc_data;
  logic [11:0] ch0_avg;
  logic [11:0] ch1_avg;
  logic        avg_valid;
  logic        avg_ch;
  logic        overrun;
  logic        timeout_err;

  adc_sample_scheduler #(
    .NUM_CH(2),
    .SAMPLE_DIV(10),
    .AVG_LOG2(2),
    .TIMEOUT(20)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .RESET_N(RESET_N),
    .ch_en(ch_en),
    .adc_start(adc_start),
    .adc_ch(adc_ch),
    .adc_done(adc_done),
    .adc_data(adc_data),
    .ch0_avg(ch0_avg),
    .ch1_avg(ch1_avg),
    .avg_valid(avg_valid),
    .avg_ch(avg_ch),
    .overrun(overrun),
    .timeout_err(timeout_err)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int errors = 0;

  // ADC model: done pulse dly cycles after start (dly 0: never).
  logic [11:0] q0 [$];
  logic [11:0] q1 [$];
  int   dly = 5;
  int   cd  = -1;
  logic mch = 1'b0;

  always @(negedge CLOCK_50) begin
    adc_done = 1'b0;
    if (!RESET_N) cd = -1;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        adc_done = 1'b1;
        if (mch == 1'b0 && q0.size() > 0)
          adc_data = q0.pop_front();
        else if (mch == 1'b1 && q1.size() > 0)
          adc_data = q1.pop_front();
        else
          adc_data = 12'd0;
        cd = -1;
      end
    end
    if (adc_start && dly > 0 && RESET_N) begin
      cd  = dly;
      mch = adc_ch;
    end
  end

  // Output monitor.
  int   n_start = 0;
  int   n_valid = 0;
  logic st_q [$];
  logic ev_q [$];

  always @(negedge CLOCK_50) begin
    if (adc_start) begin
      n_start++;
      st_q.push_back(adc_ch);
    end
    if (avg_valid) begin
      n_valid++;
      ev_q.push_back(avg_ch);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic clr_mon();
    n_start = 0;
    n_valid = 0;
    st_q.delete();
    ev_q.delete();
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    run(2);
    RESET_N = 1'b1;
  endtask

  task automatic wait_start(input int max, output int k);
    k = -1;
    for (int j = 1; j <= max; j++) begin
      @(negedge CLOCK_50);
      if (adc_start) begin
        k = j;
        break;
      end
    end
  endtask

  typedef struct packed {
    logic [1:0]  en;
    logic [47:0] d0;
    logic [47:0] d1;
    int          cyc;
    int          nv;
    int          ns;
    logic [11:0] e0;
    logic [11:0] e1;
    logic        fch;
  } vec_t;

  function automatic vec_t mk(
    input logic [1:0] en, input logic [47:0] d0,
    input logic [47:0] d1, input int cyc, input int nv,
    input int ns, input logic [11:0] e0,
    input logic [11:0] e1, input logic fch);
    vec_t v;
    v.en  = en;
    v.d0  = d0;
    v.d1  = d1;
    v.cyc = cyc;
    v.nv  = nv;
    v.ns  = ns;
    v.e0  = e0;
    v.e1  = e1;
    v.fch = fch;
    return v;
  endfunction

  vec_t tbl [5];

  initial begin
    int   k;
    int   bad;
    logic exp_ch;
    logic [11:0] w;

    tbl[0] = mk(2'b01, {12'd112, 12'd108, 12'd104, 12'd100},
                48'd0, 48, 1, 4, 12'd106, 12'd0, 1'b0);
    tbl[1] = mk(2'b11, {4{12'd4095}},
                {12'd2, 12'd2, 12'd2, 12'd1},
                88, 2, 8, 12'd4095, 12'd1, 1'b0);
    tbl[2] = mk(2'b10, 48'd0,
                {12'd41, 12'd30, 12'd20, 12'd10},
                48, 1, 4, 12'd0, 12'd25, 1'b1);
    tbl[3] = mk(2'b00, 48'd0, 48'd0,
                48, 0, 0, 12'd0, 12'd0, 1'b0);
    tbl[4] = mk(2'b01, {12'd4, 12'd2, 12'd1, 12'd0},
                48'd0, 48, 1, 4, 12'd1, 12'd0, 1'b0);

    RESET_N  = 1'b0;
    ch_en    = 2'b00;
    adc_done = 1'b0;
    adc_data = 12'd0;
    run(2);
    #1;
    chk("reset_outputs",
        int'({adc_start, adc_ch, avg_valid, avg_ch,
              overrun, timeout_err, ch0_avg, ch1_avg}), 0);

    // Vector table.
    for (int i = 0; i < 5; i++) begin
      dly   = 5;
      ch_en = tbl[i].en;
      q0.delete();
      q1.delete();
      for (int j = 0; j < 4; j++) begin
        w = tbl[i].d0[12*j +: 12];
        q0.push_back(w);
        w = tbl[i].d1[12*j +: 12];
        q1.push_back(w);
      end
      RESET_N = 1'b0;
      run(1);
      clr_mon();
      run(1);
      RESET_N = 1'b1;
      run(tbl[i].cyc);
      #1;
      chk($sformatf("row%0d_nstart", i), n_start, tbl[i].ns);
      chk($sformatf("row%0d_nvalid", i), n_valid, tbl[i].nv);
      chk($sformatf("row%0d_ch0_avg", i), int'(ch0_avg), int'(tbl[i].e0));
      chk($sformatf("row%0d_ch1_avg", i), int'(ch1_avg), int'(tbl[i].e1));
      chk($sformatf("row%0d_flags", i), int'({overrun, timeout_err}), 0);
      if (tbl[i].nv > 0 && ev_q.size() > 0)
        chk($sformatf("row%0d_avg_ch", i), int'(ev_q[0]), int'(tbl[i].fch));
      bad = 0;
      foreach (st_q[j]) begin
        if (tbl[i].en == 2'b11) exp_ch = 1'(j % 2);
        else                    exp_ch = (tbl[i].en == 2'b10);
        if (st_q[j] !== exp_ch) bad++;
      end
      chk($sformatf("row%0d_adc_ch_seq", i), bad, 0);
    end

    // Converter never answers: timeout, then retry on a later tick.
    dly   = 0;
    ch_en = 2'b01;
    q0.delete();
    q1.delete();
    clr_mon();
    do_reset();
    wait_start(20, k);
    chk("to_first_start", k, 10);
    run(18);
    #1;
    chk("to_not_yet", int'(timeout_err), 0);
    run(6);
    #1;
    chk("to_set", int'(timeout_err), 1);
    chk("to_overrun", int'(overrun), 1);
    dly = 5;
    q0.push_back(12'd7);
    wait_start(15, k);
    chk("to_retry_start", int'(k > 0), 1);
    run(10);
    #1;
    chk("to_sticky", int'(timeout_err), 1);

    // Slow converter: one tick dropped per conversion.
    dly   = 12;
    ch_en = 2'b01;
    q0.delete();
    q1.delete();
    q0.push_back(12'd100);
    q0.push_back(12'd104);
    q0.push_back(12'd108);
    q0.push_back(12'd112);
    RESET_N = 1'b0;
    run(1);
    clr_mon();
    run(1);
    RESET_N = 1'b1;
    run(86);
    #1;
    chk("ovr_flag", int'(overrun), 1);
    chk("ovr_nstart", n_start, 4);
    chk("ovr_nvalid", n_valid, 1);
    chk("ovr_ch0_avg", int'(ch0_avg), 106);
    chk("ovr_timeout", int'(timeout_err), 0);

    // Reset for one cycle while a conversion is in WAIT.
    dly = 5;
    wait_start(10, k);
    chk("rst_pre_start", int'(k > 0), 1);
    run(2);
    RESET_N = 1'b0;
    run(1);
    #1;
    chk("rst_overrun_clr", int'(overrun), 0);
    chk("rst_avg_clr", int'(ch0_avg), 0);
    chk("rst_all_zero",
        int'({adc_start, adc_ch, avg_valid, avg_ch,
              overrun, timeout_err, ch0_avg, ch1_avg}), 0);
    RESET_N = 1'b1;
    wait_start(15, k);
    chk("rst_first_start", k, 10);

    // Channel 0 disabled after 2 samples, re-enabled later.
    dly   = 5;
    ch_en = 2'b11;
    q0.delete();
    q1.delete();
    q0.push_back(12'd1000);
    q0.push_back(12'd1000);
    q0.push_back(12'd8);
    q0.push_back(12'd8);
    q0.push_back(12'd12);
    q0.push_back(12'd12);
    for (int j = 0; j < 8; j++) q1.push_back(12'd40);
    RESET_N = 1'b0;
    run(1);
    clr_mon();
    run(1);
    RESET_N = 1'b1;
    run(45);
    ch_en = 2'b10;
    run(23);
    #1;
    chk("dis_ch1_avg", int'(ch1_avg), 40);
    chk("dis_ch0_none", int'(ch0_avg), 0);
    ch_en = 2'b11;
    run(72);
    #1;
    chk("dis_ch0_fresh", int'(ch0_avg), 10);
    chk("dis_nvalid", n_valid, 2);
    if (ev_q.size() == 2)
      chk("dis_last_ch", int'(ev_q[1]), 0);
    else
      chk("dis_ev_count", ev_q.size(), 2);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
